// File: rtl/apb_v3_master_arbiter_if.sv
// Bundles the two requester ports and the shared APB3 bus of the arbiter.
// Latency: none, wires only.
// Backpressure: carried by mX_req_ready and the slave's PREADY.
interface apb_v3_master_arbiter_if #(
    parameter int unsigned ADDR_BUS_WIDTH = 32,
    parameter int unsigned DATA_BUS_WIDTH = 32
);
    // Requester 0
    logic                      m0_req_valid;
    logic                      m0_req_ready;
    logic                      m0_req_write;
    logic [ADDR_BUS_WIDTH-1:0] m0_req_addr;
    logic [DATA_BUS_WIDTH-1:0] m0_req_wdata;
    logic                      m0_rsp_valid;
    logic [DATA_BUS_WIDTH-1:0] m0_rsp_rdata;
    logic                      m0_rsp_err;
    // Requester 1
    logic                      m1_req_valid;
    logic                      m1_req_ready;
    logic                      m1_req_write;
    logic [ADDR_BUS_WIDTH-1:0] m1_req_addr;
    logic [DATA_BUS_WIDTH-1:0] m1_req_wdata;
    logic                      m1_rsp_valid;
    logic [DATA_BUS_WIDTH-1:0] m1_rsp_rdata;
    logic                      m1_rsp_err;
    // Shared APB3 bus
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_BUS_WIDTH-1:0] PADDR;
    logic [DATA_BUS_WIDTH-1:0] PWDATA;
    logic [DATA_BUS_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    // Arbiter's view of the bundle.
    modport master (
        input  m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata,
        output m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
        input  m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata,
        output m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    // Environment's view: the two requesters plus the APB slave.
    modport slave (
        output m0_req_valid, m0_req_write, m0_req_addr, m0_req_wdata,
        input  m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
        output m1_req_valid, m1_req_write, m1_req_addr, m1_req_wdata,
        input  m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_v3_master_arbiter.sv
// Two-requester round-robin APB3 master with a wait-state watchdog.
// Latency: accept at T, SETUP T+1, ACCESS T+2.., rsp strobe one cycle after PREADY (T+3 at zero wait).
// Backpressure: req_ready only in IDLE for the granted requester; slave stalls via PREADY, bounded by TIMEOUT_CYC.
module apb_v3_master_arbiter #(
    parameter int unsigned ADDR_BUS_WIDTH = 32,
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYC    = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_v3_master_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A zero limit switches the watchdog off entirely.
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    localparam bit          TO_EN  = (TIMEOUT_CYC != 0);

    state_t                    state_q,      state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      gnt_idx_q,    gnt_idx_d;
    logic                      write_q,      write_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_BUS_WIDTH-1:0] wdata_q,      wdata_d;
    logic [15:0]               wd_cnt_q,     wd_cnt_d;
    logic [1:0]                rsp_vld_q,    rsp_vld_d;
    logic [DATA_BUS_WIDTH-1:0] rsp_rdata0_q, rsp_rdata0_d;
    logic [DATA_BUS_WIDTH-1:0] rsp_rdata1_q, rsp_rdata1_d;
    logic                      rsp_err0_q,   rsp_err0_d;
    logic                      rsp_err1_q,   rsp_err1_d;

    logic       gnt_any;
    logic       gnt_sel;
    logic       accept;
    logic       done_ok;
    logic       done_to;
    logic [DATA_BUS_WIDTH-1:0] rsp_rdata;
    logic       rsp_err;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        gnt_any = bus.m0_req_valid | bus.m1_req_valid;
        gnt_sel = (bus.m0_req_valid && bus.m1_req_valid) ? ~last_grant_q : bus.m1_req_valid;
        accept  = (state_q == ST_IDLE) && !PRESET && gnt_any;
    end

    assign bus.m0_req_ready = accept && !gnt_sel;
    assign bus.m1_req_ready = accept &&  gnt_sel;

    assign bus.PSEL    = (state_q != ST_IDLE);
    assign bus.PENABLE = (state_q == ST_ACCESS);
    assign bus.PWRITE  = write_q;
    assign bus.PADDR   = addr_q;
    assign bus.PWDATA  = wdata_q;

    assign bus.m0_rsp_valid = rsp_vld_q[0];
    assign bus.m1_rsp_valid = rsp_vld_q[1];
    assign bus.m0_rsp_rdata = rsp_rdata0_q;
    assign bus.m1_rsp_rdata = rsp_rdata1_q;
    assign bus.m0_rsp_err   = rsp_err0_q;
    assign bus.m1_rsp_err   = rsp_err1_q;

    // FSM next state, request capture, watchdog and response formation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wd_cnt_d     = wd_cnt_q;
        done_ok      = 1'b0;
        done_to      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_grant_d = gnt_sel;
                    gnt_idx_d    = gnt_sel;
                    write_d      = gnt_sel ? bus.m1_req_write : bus.m0_req_write;
                    addr_d       = gnt_sel ? bus.m1_req_addr  : bus.m0_req_addr;
                    wdata_d      = gnt_sel ? bus.m1_req_wdata : bus.m0_req_wdata;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wd_cnt_d = 16'd0;
                state_d  = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A PREADY arriving on the limit cycle still completes normally.
                if (bus.PREADY) begin
                    done_ok = 1'b1;
                    state_d = ST_IDLE;
                end else if (TO_EN && (wd_cnt_q == TO_LIM)) begin
                    done_to = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_rdata = '0;
        rsp_err   = 1'b1;
        if (done_ok) begin
            rsp_rdata = write_q ? '0 : bus.PRDATA;
            rsp_err   = bus.PSLVERR;
        end

        // Response fields only change on their own requester's strobe.
        rsp_vld_d    = 2'b00;
        rsp_rdata0_d = rsp_rdata0_q;
        rsp_rdata1_d = rsp_rdata1_q;
        rsp_err0_d   = rsp_err0_q;
        rsp_err1_d   = rsp_err1_q;
        if (done_ok || done_to) begin
            if (gnt_idx_q) begin
                rsp_vld_d[1] = 1'b1;
                rsp_rdata1_d = rsp_rdata;
                rsp_err1_d   = rsp_err;
            end else begin
                rsp_vld_d[0] = 1'b1;
                rsp_rdata0_d = rsp_rdata;
                rsp_err0_d   = rsp_err;
            end
        end
    end

    // State and datapath registers; reset drops the bus and any pending response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_idx_q    <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wd_cnt_q     <= 16'd0;
            rsp_vld_q    <= 2'b00;
            rsp_rdata0_q <= '0;
            rsp_rdata1_q <= '0;
            rsp_err0_q   <= 1'b0;
            rsp_err1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wd_cnt_q     <= wd_cnt_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_rdata0_q <= rsp_rdata0_d;
            rsp_rdata1_q <= rsp_rdata1_d;
            rsp_err0_q   <= rsp_err0_d;
            rsp_err1_q   <= rsp_err1_d;
        end
    end

endmodule

// File: doc/apb_v3_master_arbiter.md
# apb_v3_master_arbiter

Two-requester APB3 master that shares one APB bus to the `apb_v3_sram` slave. Each requester has a valid/ready request port and a one-cycle response strobe. The block arbitrates round-robin, runs the APB SETUP/ACCESS sequence and honours slave wait states. A wait-state watchdog terminates transfers that the slave never completes.

## Interface
- `ADDR_BUS_WIDTH`, 32: address width, shared by requesters and `PADDR`.
- `DATA_BUS_WIDTH`, 32: data width for `PWDATA`, `PRDATA` and requester data.
- `TIMEOUT_CYC`, 256: maximum ACCESS cycles with `PREADY`=0 before abort. 0 disables the watchdog. Legal range is 0..65535.

Ports:
- `PCLK` in 1: single clock.
- `PRESET` in 1: asynchronous, active-high reset.
- `m0_req_valid` / `m1_req_valid` in 1: request pending.
- `m0_req_ready` / `m1_req_ready` out 1: request accepted this cycle.
- `m0_req_write` / `m1_req_write` in 1: 1 for write, 0 for read.
- `m0_req_addr` / `m1_req_addr` in ADDR_BUS_WIDTH: address.
- `m0_req_wdata` / `m1_req_wdata` in DATA_BUS_WIDTH: write data.
- `m0_rsp_valid` / `m1_rsp_valid` out 1: one-cycle completion strobe.
- `m0_rsp_rdata` / `m1_rsp_rdata` out DATA_BUS_WIDTH: read data.
- `m0_rsp_err` / `m1_rsp_err` out 1: `PSLVERR` or timeout.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB control.
- `PADDR` out ADDR_BUS_WIDTH, `PWDATA` out DATA_BUS_WIDTH: APB address and write data.
- `PRDATA` in DATA_BUS_WIDTH, `PREADY` in 1, `PSLVERR` in 1: APB slave response.

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset state is IDLE.
- **IDLE:**
  - Arbitration is evaluated every cycle. `mX_req_ready` is combinational: it is 1 only in IDLE and only for the granted requester.
  - Acceptance occurs when `mX_req_valid && mX_req_ready`. On acceptance, write/addr/wdata and the grant index are registered, and the FSM moves to SETUP.
- **Round-robin:**
  - `last_grant` resets to 1, so m0 wins the first tie.
  - When only one requester is valid, it is granted.
  - When both are valid, the requester other than `last_grant` is granted.
  - `last_grant` updates on acceptance.
- **SETUP:** `PSEL`=1, `PENABLE`=0, with `PADDR`/`PWRITE`/`PWDATA` driven from the registers. Lasts exactly one cycle, then ACCESS.
- **ACCESS:**
  - `PSEL`=1 and `PENABLE`=1. Address and control are held stable.
  - On `PREADY`=1, the transfer completes:
    - `rsp_valid` is pulsed next cycle to the granted requester.
    - `rsp_err` = `PSLVERR`.
    - `rsp_rdata` = `PRDATA` for reads and 0 for writes.
    - The FSM moves to IDLE.
- **Watchdog:**
  - A 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `PREADY`=0.
  - When the counter equals `TIMEOUT_CYC` (nonzero), the FSM moves to IDLE and the bus is released.
  - The response has `rsp_err`=1 and `rsp_rdata`=0.
  - If `PREADY`=1 arrives in the same cycle the count is reached, normal completion wins.
- The non-granted requester never sees `rsp_valid`. Its pending request waits in IDLE; the block does not drop it.
- `rsp_rdata`/`rsp_err` hold their value between strobes. They are valid only while `rsp_valid`=1.

## Timing
- Reset values:
  - `PSEL`, `PENABLE`, `PWRITE` = 0; `PADDR`, `PWDATA` = 0.
  - All `rsp_valid`, `rsp_err` = 0; all `rsp_rdata` = 0.
  - `req_ready` = 0 during reset.
- Reset asserted mid-transfer:
  - APB outputs go to 0 asynchronously.
  - No response is issued for the aborted transfer.
  - The FSM returns to IDLE and `last_grant` returns to 1.
- Latency for a zero-wait transfer:
  - Acceptance at cycle T, SETUP at T+1, ACCESS at T+2 with `PREADY` sampled.
  - `rsp_valid` at T+3, and IDLE again at T+3.
  - Each slave wait cycle adds one cycle.
- Minimum spacing between APB transfers is 3 cycles (IDLE, SETUP, ACCESS). `PSEL` drops for at least one cycle between transfers.
- A new acceptance may occur in the same cycle as the `rsp_valid` of the previous transfer.
- Timeout abort: `rsp_valid` occurs `TIMEOUT_CYC`+3 cycles after acceptance. `PSEL`/`PENABLE` are 0 in that cycle.

## Test plan
- **Single write/read:** m0 writes 0xDEADBEEF to 0x10, then reads 0x10 with the slave at zero wait. Required response:
  - `PSEL`/`PENABLE` follow SETUP then ACCESS.
  - `m0_rsp_valid` arrives 3 cycles after acceptance.
  - `m0_rsp_rdata` = 0xDEADBEEF and `rsp_err` = 0.
- **Contention:** m0 and m1 both hold valid continuously for 4 requests each, writing to distinct addresses 0x00..0x1C. Required response:
  - Grants alternate m0, m1, m0, m1, and so on.
  - Each requester receives exactly 4 strobes, and readback matches.
- **Wait states:** the slave inserts 5 wait cycles. Required response:
  - `PADDR`/`PWRITE`/`PWDATA` stay stable through ACCESS.
  - `rsp_valid` arrives at acceptance+8.
- **Slave error:** `PSLVERR`=1 is returned with `PREADY` on an out-of-range address. Required response: `m1_rsp_err`=1 and the FSM returns to IDLE.
- **Timeout:** `TIMEOUT_CYC`=4 and `PREADY` is tied to 0. Required response:
  - The bus is released, with `rsp_valid` and `rsp_err`=1 at acceptance+7.
  - A subsequent request with `PREADY` restored completes normally.
- **Reset mid-transfer:** `PRESET` is asserted during ACCESS. Required response:
  - APB outputs go to 0 immediately, with no `rsp_valid`.
  - After release, the first tie is granted to m0.
